// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/result bundle between the EX stage and the
// iterative multiply/divide unit. The master side issues operations and
// MTHI/MTLO moves; the slave side (muldiv_unit) returns HI/LO and status.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] data2;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    modport master (
        output start, op, data1, data2, mthi, mtlo, wr_data,
        input  hi, lo, busy, done
    );

    modport slave (
        input  start, op, data1, data2, mthi, mtlo, wr_data,
        output hi, lo, busy, done
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU for the MIPS EX stage.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle, on
// operand magnitudes; signs are applied in a final FIX cycle that writes
// the architectural HI/LO registers.
// Optional feature: define MULDIV_EARLY_OUT_EN to let a multiply leave for
// FIX as soon as the remaining multiplier magnitude is zero.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    muldiv_unit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0]   ONE_W  = 1;
    localparam logic [2*WIDTH-1:0] ONE_2W = 1;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_opA;
    logic [WIDTH-1:0]   r_opB;
    logic [CW-1:0]      r_count;
    logic               r_isDiv;
    logic               r_negRes;
    logic               r_negRem;
    logic               r_divZero;

    logic               w_signed;
    logic [WIDTH-1:0]   w_absA;
    logic [WIDTH-1:0]   w_absB;
    logic [2*WIDTH-1:0] w_mulAcc;
    logic [WIDTH-1:0]   w_mplierNext;
    logic               w_mulLast;
    logic [WIDTH:0]     w_divPart;
    logic [WIDTH:0]     w_divDiff;
    logic               w_divFits;
    logic [WIDTH-1:0]   w_newRem;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;

    assign w_signed = ~bus.op[0];
    assign w_absA   = (w_signed && bus.data1[WIDTH-1]) ? (~bus.data1 + ONE_W) : bus.data1;
    assign w_absB   = (w_signed && bus.data2[WIDTH-1]) ? (~bus.data2 + ONE_W) : bus.data2;

    // Multiply step: add the left-shifting multiplicand when the current
    // multiplier LSB is set.
    assign w_mulAcc     = r_acc + (r_opB[0] ? r_opA : '0);
    assign w_mplierNext = r_opB >> 1;

`ifdef MULDIV_EARLY_OUT_EN
    assign w_mulLast = (w_mplierNext == '0);
`else
    assign w_mulLast = (r_count == CW'(WIDTH - 1));
`endif

    // Restoring divide step: remainder lives in r_acc's upper half, the
    // quotient shifts into the lower half, dividend bits come from r_opA.
    assign w_divPart = {r_acc[2*WIDTH-1:WIDTH], r_opA[WIDTH-1]};
    assign w_divDiff = w_divPart - {1'b0, r_opB};
    assign w_divFits = ~w_divDiff[WIDTH];
    assign w_newRem  = w_divFits ? w_divDiff[WIDTH-1:0] : w_divPart[WIDTH-1:0];

    // Sign correction applied in FIX. A zero divisor leaves the dividend
    // magnitude as remainder, which re-signed equals the raw dividend.
    assign w_prod = r_negRes ? (~r_acc + ONE_2W) : r_acc;
    assign w_quot = r_divZero ? '1 :
                    (r_negRes ? (~r_acc[WIDTH-1:0] + ONE_W) : r_acc[WIDTH-1:0]);
    assign w_rem  = r_negRem ? (~r_acc[2*WIDTH-1:WIDTH] + ONE_W) : r_acc[2*WIDTH-1:WIDTH];

    // Control FSM with registered HI/LO, busy and done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_hi      <= '0;
            r_lo      <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_acc     <= '0;
            r_opA     <= '0;
            r_opB     <= '0;
            r_count   <= '0;
            r_isDiv   <= 1'b0;
            r_negRes  <= 1'b0;
            r_negRem  <= 1'b0;
            r_divZero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_opA     <= {{WIDTH{1'b0}}, w_absA};
                        r_opB     <= w_absB;
                        r_acc     <= '0;
                        r_count   <= '0;
                        r_isDiv   <= bus.op[1];
                        r_negRes  <= w_signed & (bus.data1[WIDTH-1] ^ bus.data2[WIDTH-1]);
                        r_negRem  <= w_signed & bus.data1[WIDTH-1];
                        r_divZero <= (bus.data2 == '0);
                        r_busy    <= 1'b1;
                        r_state   <= bus.op[1] ? DIV : MUL;
                    end else begin
                        if (bus.mthi) r_hi <= bus.wr_data;
                        if (bus.mtlo) r_lo <= bus.wr_data;
                    end
                end
                MUL: begin
                    r_acc   <= w_mulAcc;
                    r_opA   <= r_opA << 1;
                    r_opB   <= w_mplierNext;
                    r_count <= r_count + CW'(1);
                    if (w_mulLast) r_state <= FIX;
                end
                DIV: begin
                    r_acc   <= {w_newRem, r_acc[WIDTH-2:0], w_divFits};
                    r_opA   <= r_opA << 1;
                    r_count <= r_count + CW'(1);
                    if (r_count == CW'(WIDTH - 1)) r_state <= FIX;
                end
                FIX: begin
                    if (r_isDiv) begin
                        r_hi <= w_rem;
                        r_lo <= w_quot;
                    end else begin
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod[WIDTH-1:0];
                    end
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: table-driven check of muldiv_unit results and latency,
// plus hand-written sequences for moves, busy-time requests, back-to-back
// starts and reset during an operation.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checkCount = 0;
    int   failCount  = 0;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expHi;
        logic [31:0] expLo;
    } vec_t;

    vec_t vecs[11];

    // Free-running 100 MHz style clock.
    always #5 clk = ~clk;

    muldiv_unit_if #(.WIDTH(32)) bus ();

    muldiv_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Compare one value and report a mismatch with both values.
    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Expected busy length: fixed 33, or 1 + max(1, bitlen|b|) for early-out multiplies.
    function automatic int expLatency(input logic [1:0] op, input logic [31:0] b);
        int latency;
        latency = 33;
`ifdef MULDIV_EARLY_OUT_EN
        if (!op[1]) begin
            logic [31:0] mag;
            int          len;
            mag = (!op[0] && b[31]) ? (~b + 32'd1) : b;
            len = 1;
            for (int i = 0; i < 32; i++) if (mag[i]) len = i + 1;
            latency = len + 1;
        end
`endif
        return latency;
    endfunction

    // Pulse start for one cycle; returns #1 after the sampling edge.
    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.data1 = a;
        bus.data2 = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Count edges until busy falls, with a bounded wait.
    task automatic waitIdle(output int cycles);
        cycles = 0;
        while (bus.busy && cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        if (bus.busy) checkOutput("busyTimeout", 64'(bus.busy), 64'(0));
    endtask

    // Launch an operation and wait for its completion.
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, output int cycles);
        launch(op, a, b);
        checkOutput("busyAfterStart", 64'(bus.busy), 64'(1));
        waitIdle(cycles);
    endtask

    initial begin
        int cycles;

        bus.start   = 1'b0;
        bus.op      = 2'b00;
        bus.data1   = '0;
        bus.data2   = '0;
        bus.mthi    = 1'b0;
        bus.mtlo    = 1'b0;
        bus.wr_data = '0;

        vecs[0]  = '{"MULTU_7x6",      2'b01, 32'd7,        32'd6,        32'h00000000, 32'd42};
        vecs[1]  = '{"MULT_m3x5",      2'b00, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[2]  = '{"DIV_m7d2",       2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{"DIVU_7d2",       2'b11, 32'd7,        32'd2,        32'd1,        32'd3};
        vecs[4]  = '{"DIVU_9d0",       2'b11, 32'd9,        32'd0,        32'd9,        32'hFFFFFFFF};
        vecs[5]  = '{"DIV_minDm1",     2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[6]  = '{"MULTU_maxxmax",  2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[7]  = '{"DIV_7dm2",       2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
        vecs[8]  = '{"MULT_minx2",     2'b00, 32'h80000000, 32'd2,        32'hFFFFFFFF, 32'h00000000};
        vecs[9]  = '{"DIV_m9d0",       2'b10, 32'hFFFFFFF7, 32'd0,        32'hFFFFFFF7, 32'hFFFFFFFF};
        vecs[10] = '{"MULTU_0x12345",  2'b01, 32'd0,        32'h12345,    32'h00000000, 32'h00000000};

        repeat (2) @(posedge clk);
        #1;
        checkOutput("resetHi",   64'(bus.hi),   64'(0));
        checkOutput("resetLo",   64'(bus.lo),   64'(0));
        checkOutput("resetBusy", 64'(bus.busy), 64'(0));
        checkOutput("resetDone", 64'(bus.done), 64'(0));
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, cycles);
            checkOutput($sformatf("%s latency", vecs[i].name), 64'(cycles), 64'(expLatency(vecs[i].op, vecs[i].b)));
            checkOutput($sformatf("%s done", vecs[i].name), 64'(bus.done), 64'(1));
            checkOutput($sformatf("%s hi", vecs[i].name), 64'(bus.hi), 64'(vecs[i].expHi));
            checkOutput($sformatf("%s lo", vecs[i].name), 64'(bus.lo), 64'(vecs[i].expLo));
            @(posedge clk);
            #1;
            checkOutput($sformatf("%s donePulse", vecs[i].name), 64'(bus.done), 64'(0));
        end

        @(negedge clk);
        bus.mthi    = 1'b1;
        bus.wr_data = 32'hCAFE0000;
        @(posedge clk);
        #1;
        bus.mthi = 1'b0;
        checkOutput("mthiOnly hi", 64'(bus.hi), 64'(32'hCAFE0000));

        @(negedge clk);
        bus.mthi    = 1'b1;
        bus.mtlo    = 1'b1;
        bus.wr_data = 32'hA5A55A5A;
        @(posedge clk);
        #1;
        bus.mthi = 1'b0;
        bus.mtlo = 1'b0;
        checkOutput("mthiMtlo hi", 64'(bus.hi), 64'(32'hA5A55A5A));
        checkOutput("mthiMtlo lo", 64'(bus.lo), 64'(32'hA5A55A5A));

        launch(2'b01, 32'd3, 32'd4);
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus.mthi    = 1'b1;
        bus.wr_data = 32'h1234;
        bus.start   = 1'b1;
        bus.op      = 2'b11;
        bus.data1   = 32'd100;
        bus.data2   = 32'd7;
        @(posedge clk);
        #1;
        bus.mthi  = 1'b0;
        bus.start = 1'b0;
        checkOutput("busyMthi hi", 64'(bus.hi), 64'(32'hA5A55A5A));
        checkOutput("busyMthi busy", 64'(bus.busy), 64'(1));
        waitIdle(cycles);
        checkOutput("busyStart hi", 64'(bus.hi), 64'(0));
        checkOutput("busyStart lo", 64'(bus.lo), 64'(12));

        @(posedge clk);
        #1;
        @(negedge clk);
        bus.mtlo    = 1'b1;
        bus.wr_data = 32'hDEADBEEF;
        bus.start   = 1'b1;
        bus.op      = 2'b01;
        bus.data1   = 32'd2;
        bus.data2   = 32'd3;
        @(posedge clk);
        #1;
        bus.mtlo  = 1'b0;
        bus.start = 1'b0;
        checkOutput("startMtlo loHeld", 64'(bus.lo), 64'(12));
        waitIdle(cycles);
        checkOutput("startMtlo lo", 64'(bus.lo), 64'(6));
        checkOutput("startMtlo done", 64'(bus.done), 64'(1));

        launch(2'b01, 32'd5, 32'd5);
        checkOutput("backToBack busy", 64'(bus.busy), 64'(1));
        checkOutput("backToBack done", 64'(bus.done), 64'(0));
        waitIdle(cycles);
        checkOutput("backToBack lo", 64'(bus.lo), 64'(25));

        launch(2'b01, 32'd5, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("midReset busy", 64'(bus.busy), 64'(0));
        checkOutput("midReset hi",   64'(bus.hi),   64'(0));
        checkOutput("midReset lo",   64'(bus.lo),   64'(0));
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(2'b01, 32'd3, 32'd3, cycles);
        checkOutput("afterReset lo", 64'(bus.lo), 64'(9));
        checkOutput("afterReset hi", 64'(bus.hi), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end
endmodule
